sa_rdata_router: RTL and testbench

Slave-side R channel of the interconnect. It accepts read-data beats from one AXI4 slave, buffers them in a FIFO, and returns each beat to the owning master's R dispatcher. The owning master is decoded from the upper MST_ID_W bits of the slave-side RID. It is the opposite end of the dispatcher R data path: it drives the sa_R* inputs of every master dispatcher. Beats whose master index is out of range are drained internally so the slave never stalls.

---
 rtl/sa_rdata_router.sv | 120 ++++++++++++
 tb/tb_sa_rdata_router.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sa_rdata_router.sv
// rtl/sa_rdata_router.sv - slave-side R channel: FIFO-buffered routing of read beats to master dispatchers
// Optional SA_RDATA_BEAT_CNT_EN adds beat_cnt_o, a wrapping count of popped beats.
module sa_rdata_router #(
   parameter int MST_AMT        = 2,
   parameter int DATA_WIDTH     = 32,
   parameter int TRANS_MST_ID_W = 5,
   parameter int MST_ID_W       = (MST_AMT > 1) ? $clog2(MST_AMT) : 1,
   parameter int TRANS_SLV_ID_W = TRANS_MST_ID_W + MST_ID_W,
   parameter int SA_RDATA_DEPTH = 4
) (
   input  logic                                ACLK_i,
   input  logic                                ARESET_i,
   input  logic [TRANS_SLV_ID_W-1:0]           s_RID_i,
   input  logic [DATA_WIDTH-1:0]               s_RDATA_i,
   input  logic                                s_RLAST_i,
   input  logic                                s_RVALID_i,
   output logic                                s_RREADY_o,
   input  logic [MST_AMT-1:0]                  dsp_RREADY_i,
   output logic [TRANS_MST_ID_W*MST_AMT-1:0]   dsp_RID_o,
   output logic [DATA_WIDTH*MST_AMT-1:0]       dsp_RDATA_o,
   output logic [MST_AMT-1:0]                  dsp_RLAST_o,
   output logic [MST_AMT-1:0]                  dsp_RVALID_o,
   output logic                                burst_done_o,
   output logic                                err_bad_id_o
`ifdef SA_RDATA_BEAT_CNT_EN
   ,
   output logic [15:0]                         beat_cnt_o
`endif
);

   localparam int AW = $clog2(SA_RDATA_DEPTH);
   localparam int EW = TRANS_SLV_ID_W + DATA_WIDTH + 1;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_DELIVER = 2'd1;
   localparam logic [1:0] ST_DRAIN   = 2'd2;

   logic [EW-1:0]             mem_q [SA_RDATA_DEPTH];
   logic [AW:0]               wptr_q, wptr_d, rptr_q, rptr_d;
   logic                      full, empty, push, pop;
   logic                      done_q, err_q;
   logic [EW-1:0]             head;
   logic [TRANS_SLV_ID_W-1:0] head_rid;
   logic [DATA_WIDTH-1:0]     head_data;
   logic                      head_last, head_bad;
   logic [MST_ID_W-1:0]       head_mst;
   logic [1:0]                state;
   logic [MST_AMT-1:0]        rvalid_c;

   assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
   assign empty = (wptr_q == rptr_q);
   assign push  = s_RVALID_i & ~full;

   assign head      = mem_q[rptr_q[AW-1:0]];
   assign head_rid  = head[EW-1 -: TRANS_SLV_ID_W];
   assign head_data = head[DATA_WIDTH:1];
   assign head_last = head[0];
   assign head_mst  = head_rid[TRANS_SLV_ID_W-1 -: MST_ID_W];

   generate
      if ((1 << MST_ID_W) == MST_AMT) begin : g_pow2
         assign head_bad = 1'b0;
      end else begin : g_npow2
         assign head_bad = (head_mst >= MST_ID_W'(MST_AMT));
      end
   endgenerate

   // State is decoded from the current head every cycle, so a new head is
   // acted on in the same cycle it becomes visible after a pop.
   always_comb begin
      state = ST_IDLE;
      if (!empty) state = head_bad ? ST_DRAIN : ST_DELIVER;
   end

   always_comb begin
      rvalid_c = '0;
      for (int i = 0; i < MST_AMT; i++)
         rvalid_c[i] = (state == ST_DELIVER) && (head_mst == MST_ID_W'(i));
   end

   assign pop    = ((state == ST_DELIVER) && |(rvalid_c & dsp_RREADY_i)) || (state == ST_DRAIN);
   assign wptr_d = wptr_q + {{AW{1'b0}}, push};
   assign rptr_d = rptr_q + {{AW{1'b0}}, pop};

   always_ff @(posedge ACLK_i) begin
      if (push) mem_q[wptr_q[AW-1:0]] <= {s_RID_i, s_RDATA_i, s_RLAST_i};
   end

   always_ff @(posedge ACLK_i) begin
      if (ARESET_i) begin
         wptr_q <= '0;
         rptr_q <= '0;
         done_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         done_q <= pop & head_last;
         err_q  <= err_q | (state == ST_DRAIN);
      end
   end

`ifdef SA_RDATA_BEAT_CNT_EN
   logic [15:0] cnt_q;
   always_ff @(posedge ACLK_i) begin
      if (ARESET_i)  cnt_q <= 16'd0;
      else if (pop)  cnt_q <= cnt_q + 16'd1;
   end
   assign beat_cnt_o = cnt_q;
`endif

   assign s_RREADY_o   = ~full;
   assign dsp_RVALID_o = rvalid_c;
   assign dsp_RID_o    = {MST_AMT{head_rid[TRANS_MST_ID_W-1:0]}};
   assign dsp_RDATA_o  = {MST_AMT{head_data}};
   assign dsp_RLAST_o  = {MST_AMT{head_last}};
   assign burst_done_o = done_q;
   assign err_bad_id_o = err_q;

endmodule

// File: tb/tb_sa_rdata_router.sv
// tb/tb_sa_rdata_router.sv - randomized self-checking bench for sa_rdata_router (MST_AMT=3)
module tb_sa_rdata_router;

   logic        ACLK_i = 1'b0;
   logic        ARESET_i = 1'b1;
   logic [6:0]  s_RID_i = '0;
   logic [31:0] s_RDATA_i = '0;
   logic        s_RLAST_i = 1'b0;
   logic        s_RVALID_i = 1'b0;
   logic        s_RREADY_o;
   logic [2:0]  dsp_RREADY_i = '0;
   logic [14:0] dsp_RID_o;
   logic [95:0] dsp_RDATA_o;
   logic [2:0]  dsp_RLAST_o;
   logic [2:0]  dsp_RVALID_o;
   logic        burst_done_o;
   logic        err_bad_id_o;
`ifdef SA_RDATA_BEAT_CNT_EN
   logic [15:0] beat_cnt_o;
`endif

   sa_rdata_router #(.MST_AMT(3), .DATA_WIDTH(32), .TRANS_MST_ID_W(5), .SA_RDATA_DEPTH(4)) dut (
      .ACLK_i(ACLK_i), .ARESET_i(ARESET_i),
      .s_RID_i(s_RID_i), .s_RDATA_i(s_RDATA_i), .s_RLAST_i(s_RLAST_i),
      .s_RVALID_i(s_RVALID_i), .s_RREADY_o(s_RREADY_o),
      .dsp_RREADY_i(dsp_RREADY_i), .dsp_RID_o(dsp_RID_o), .dsp_RDATA_o(dsp_RDATA_o),
      .dsp_RLAST_o(dsp_RLAST_o), .dsp_RVALID_o(dsp_RVALID_o),
      .burst_done_o(burst_done_o), .err_bad_id_o(err_bad_id_o)
`ifdef SA_RDATA_BEAT_CNT_EN
      , .beat_cnt_o(beat_cnt_o)
`endif
   );

   always #5 ACLK_i = ~ACLK_i;

   typedef struct packed {
      logic [6:0]  id;
      logic [31:0] d;
      logic        l;
   } beat_t;

   // Reference model: the buffered beats in acceptance order plus output flags.
   beat_t q[$];
   beat_t tx[$];
   bit    m_done, m_err;
   int    m_cnt;
   int    n_tests, n_fail;

   function automatic beat_t make_beat(input logic [1:0] m, input logic last);
      beat_t b;
      b.id = {m, 5'($urandom_range(0, 31))};
      b.d  = $urandom();
      b.l  = last;
      return b;
   endfunction

   function automatic logic [2:0] exp_valid();
      if (q.size() == 0) return 3'b000;
      if (q[0].id[6:5] == 2'd3) return 3'b000;
      return 3'b001 << q[0].id[6:5];
   endfunction

   function automatic logic [5:0] exp_ctl();
      return {q.size() < 4, exp_valid(), m_done, m_err};
   endfunction

   function automatic logic [5:0] obs_ctl();
      return {s_RREADY_o, dsp_RVALID_o, burst_done_o, err_bad_id_o};
   endfunction

   function automatic logic [37:0] exp_head();
      return {q[0].id[4:0], q[0].d, q[0].l};
   endfunction

   function automatic logic [37:0] obs_head();
      int k;
      k = int'(q[0].id[6:5]);
      return {dsp_RID_o[k*5 +: 5], dsp_RDATA_o[k*32 +: 32], dsp_RLAST_o[k]};
   endfunction

   task automatic drive_tx();
      s_RVALID_i = (tx.size() > 0);
      if (tx.size() > 0) begin
         s_RID_i = tx[0].id; s_RDATA_i = tx[0].d; s_RLAST_i = tx[0].l;
      end
   endtask

   // Advance the model by one clock using the inputs currently applied, then clock.
   task automatic adv();
      bit popped, acc;
      popped = 0;
      acc = 0;
      if (ARESET_i) begin
         q.delete(); m_done = 0; m_err = 0; m_cnt = 0;
      end else begin
         acc = s_RVALID_i && (q.size() < 4);
         if (q.size() > 0) begin
            if (q[0].id[6:5] == 2'd3) begin popped = 1; m_err = 1; end
            else if (dsp_RREADY_i[q[0].id[6:5]]) popped = 1;
         end
         m_done = 0;
         if (popped) begin m_done = q[0].l; void'(q.pop_front()); m_cnt++; end
         if (acc) q.push_back(beat_t'({s_RID_i, s_RDATA_i, s_RLAST_i}));
      end
      if (acc && tx.size() > 0) void'(tx.pop_front());
      @(posedge ACLK_i);
      #1;
   endtask

   task automatic test_reset();
      ARESET_i = 1'b1; s_RVALID_i = 1'b0;
      adv(); adv();
      ARESET_i = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge ACLK_i);
         n_tests++;
         if (obs_ctl() !== 6'b1_000_0_0) begin
            n_fail++; $display("FAIL reset_idle got=%b want=%b", obs_ctl(), 6'b1_000_0_0);
         end
`ifdef SA_RDATA_BEAT_CNT_EN
         n_tests++;
         if (beat_cnt_o !== 16'd0) begin n_fail++; $display("FAIL reset_cnt got=%0d want=0", beat_cnt_o); end
`endif
         adv();
      end
   endtask

   task automatic test_burst();
      int nd;
      nd = 0;
      dsp_RREADY_i = 3'b111;
      for (int i = 0; i < 4; i++) begin
         beat_t b;
         b = make_beat(2'd1, i == 3);
         b.id[4:0] = 5'd3;
         tx.push_back(b);
      end
      for (int c = 0; c < 10; c++) begin
         drive_tx();
         @(negedge ACLK_i);
         n_tests++;
         if (obs_ctl() !== exp_ctl()) begin n_fail++; $display("FAIL burst_ctl c=%0d got=%b want=%b", c, obs_ctl(), exp_ctl()); end
         if (exp_valid() != 3'b000) begin
            n_tests++;
            if (obs_head() !== exp_head()) begin n_fail++; $display("FAIL burst_head got=%h want=%h", obs_head(), exp_head()); end
         end
         if (burst_done_o) nd++;
         adv();
      end
      n_tests++;
      if (nd !== 1) begin n_fail++; $display("FAIL burst_done_count got=%0d want=1", nd); end
   endtask

   task automatic test_backpressure();
      int ndel;
      ndel = 0;
      dsp_RREADY_i = 3'b000;
      for (int i = 0; i < 5; i++) tx.push_back(make_beat(2'($urandom_range(0, 2)), i == 4));
      for (int c = 0; c < 20; c++) begin
         if (c == 8) dsp_RREADY_i = 3'b111;
         drive_tx();
         @(negedge ACLK_i);
         n_tests++;
         if (obs_ctl() !== exp_ctl()) begin n_fail++; $display("FAIL bp_ctl c=%0d got=%b want=%b", c, obs_ctl(), exp_ctl()); end
         if (exp_valid() != 3'b000) begin
            n_tests++;
            if (obs_head() !== exp_head()) begin n_fail++; $display("FAIL bp_head got=%h want=%h", obs_head(), exp_head()); end
         end
         if (c == 7) begin
            n_tests++;
            if (s_RREADY_o !== 1'b0) begin n_fail++; $display("FAIL bp_full_ready got=%b want=0", s_RREADY_o); end
         end
         if (|(dsp_RVALID_o & dsp_RREADY_i)) ndel++;
         adv();
      end
      n_tests++;
      if (ndel !== 5) begin n_fail++; $display("FAIL bp_delivered got=%0d want=5", ndel); end
   endtask

   task automatic test_interleave();
      logic [2:0] seq[$];
      dsp_RREADY_i = 3'b111;
      tx.push_back(make_beat(2'd0, 1'b1));
      tx.push_back(make_beat(2'd1, 1'b1));
      tx.push_back(make_beat(2'd0, 1'b1));
      for (int c = 0; c < 8; c++) begin
         drive_tx();
         @(negedge ACLK_i);
         n_tests++;
         if (obs_ctl() !== exp_ctl()) begin n_fail++; $display("FAIL il_ctl c=%0d got=%b want=%b", c, obs_ctl(), exp_ctl()); end
         if (exp_valid() != 3'b000) begin
            n_tests++;
            if (obs_head() !== exp_head()) begin n_fail++; $display("FAIL il_head got=%h want=%h", obs_head(), exp_head()); end
         end
         if (dsp_RVALID_o != 3'b000) seq.push_back(dsp_RVALID_o);
         adv();
      end
      n_tests++;
      if (seq.size() != 3 || seq[0] !== 3'b001 || seq[1] !== 3'b010 || seq[2] !== 3'b001) begin
         n_fail++; $display("FAIL il_sequence got_len=%0d want=001,010,001", seq.size());
      end
   endtask

   task automatic test_bad_id();
      int nd;
      nd = 0;
      dsp_RREADY_i = 3'b111;
      tx.push_back(make_beat(2'd3, 1'b1));
      tx.push_back(make_beat(2'd2, 1'b1));
      for (int c = 0; c < 10; c++) begin
         drive_tx();
         @(negedge ACLK_i);
         n_tests++;
         if (obs_ctl() !== exp_ctl()) begin n_fail++; $display("FAIL bad_ctl c=%0d got=%b want=%b", c, obs_ctl(), exp_ctl()); end
         if (exp_valid() != 3'b000) begin
            n_tests++;
            if (obs_head() !== exp_head()) begin n_fail++; $display("FAIL bad_head got=%h want=%h", obs_head(), exp_head()); end
         end
         if (burst_done_o) nd++;
         adv();
      end
      n_tests++;
      if (nd !== 2 || err_bad_id_o !== 1'b1) begin
         n_fail++; $display("FAIL bad_summary done=%0d err=%b want done=2 err=1", nd, err_bad_id_o);
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         if (tx.size() == 0 && c < 380 && $urandom_range(0, 2) != 0)
            tx.push_back(make_beat(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1))));
         dsp_RREADY_i = (c >= 380) ? 3'b111 : 3'($urandom_range(0, 7));
         drive_tx();
         @(negedge ACLK_i);
         n_tests++;
         if (obs_ctl() !== exp_ctl()) begin n_fail++; $display("FAIL rnd_ctl c=%0d got=%b want=%b", c, obs_ctl(), exp_ctl()); end
         if (exp_valid() != 3'b000) begin
            n_tests++;
            if (obs_head() !== exp_head()) begin n_fail++; $display("FAIL rnd_head c=%0d got=%h want=%h", c, obs_head(), exp_head()); end
         end
         adv();
      end
`ifdef SA_RDATA_BEAT_CNT_EN
      @(negedge ACLK_i);
      n_tests++;
      if (beat_cnt_o !== 16'(m_cnt)) begin n_fail++; $display("FAIL rnd_cnt got=%0d want=%0d", beat_cnt_o, m_cnt); end
`endif
   endtask

   task automatic test_reset_mid();
      dsp_RREADY_i = 3'b000;
      for (int i = 0; i < 3; i++) tx.push_back(make_beat(2'($urandom_range(0, 2)), 1'b0));
      tx.push_back(make_beat(2'd3, 1'b0));
      for (int c = 0; c < 5; c++) begin drive_tx(); adv(); end
      tx.delete();
      s_RVALID_i = 1'b0;
      ARESET_i = 1'b1;
      adv();
      ARESET_i = 1'b0;
      @(negedge ACLK_i);
      n_tests++;
      if (obs_ctl() !== 6'b1_000_0_0) begin n_fail++; $display("FAIL rstmid_ctl got=%b want=%b", obs_ctl(), 6'b1_000_0_0); end
`ifdef SA_RDATA_BEAT_CNT_EN
      n_tests++;
      if (beat_cnt_o !== 16'd0) begin n_fail++; $display("FAIL rstmid_cnt got=%0d want=0", beat_cnt_o); end
`endif
      dsp_RREADY_i = 3'b111;
      for (int c = 0; c < 3; c++) begin
         adv();
         @(negedge ACLK_i);
         n_tests++;
         if (obs_ctl() !== exp_ctl()) begin n_fail++; $display("FAIL rstmid_idle got=%b want=%b", obs_ctl(), exp_ctl()); end
      end
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      test_reset();
      test_burst();
      test_backpressure();
      test_interleave();
      test_bad_id();
      test_random();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
